// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin scheduler sharing one ALU; ALU_RR_SCHEDULER_PERF_EN adds perf counters
package definitions;
    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        MUL = 4'd2,
        DIV = 4'd3,
        SL  = 4'd4,
        SR  = 4'd5,
        AND = 4'd6,
        OR  = 4'd7,
        NOT = 4'd8,
        XOR = 4'd9
    } opcodes_t;
endpackage

// Shared combinational ALU: unsigned, operands zero-extended to the result width
module alu_rr_scheduler_alu #(
    parameter int DATASIZE = 8
) (
    input  logic [DATASIZE-1:0]     i_in1,
    input  logic [DATASIZE-1:0]     i_in2,
    input  definitions::opcodes_t   i_opcode,
    output logic [2*DATASIZE-1:0]   o_result
);
    logic [2*DATASIZE-1:0] w_a;
    logic [2*DATASIZE-1:0] w_b;

    assign w_a = {{DATASIZE{1'b0}}, i_in1};
    assign w_b = {{DATASIZE{1'b0}}, i_in2};

    // Operation select; DIV by zero is left undefined here and masked by the scheduler
    always_comb begin
        o_result = '0;
        case (i_opcode)
            definitions::ADD: o_result = w_a + w_b;
            definitions::SUB: o_result = w_a - w_b;
            definitions::MUL: o_result = w_a * w_b;
            definitions::DIV: o_result = w_a / w_b;
            definitions::SL:  o_result = w_a << 1;
            definitions::SR:  o_result = w_a >> 1;
            definitions::AND: o_result = w_a & w_b;
            definitions::OR:  o_result = w_a | w_b;
            definitions::NOT: o_result = {{DATASIZE{1'b0}}, ~i_in1};
            definitions::XOR: o_result = w_a ^ w_b;
            default:          o_result = '0;
        endcase
    end
endmodule

module alu_rr_scheduler
    import definitions::*;
#(
    parameter int DATASIZE      = 8,
    parameter int NUM_REQ       = 4,
    parameter int MULDIV_CYCLES = 4,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [DATASIZE-1:0]   req_in1 [NUM_REQ],
    input  logic [DATASIZE-1:0]   req_in2 [NUM_REQ],
    input  opcodes_t              req_opcode [NUM_REQ],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATASIZE-1:0] out_result,
    output logic [ID_W-1:0]       out_id,
    output logic                  out_err
`ifdef ALU_RR_SCHEDULER_PERF_EN
    ,
    output logic [15:0]           ops_done,
    output logic [15:0]           busy_cycles
`endif
);
    localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       r_id;
    logic [DATASIZE-1:0]   r_in1;
    logic [DATASIZE-1:0]   r_in2;
    opcodes_t              r_opcode;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_found;
    logic [ID_W-1:0]       w_grant;
    logic                  w_accept;
    logic                  w_grant_muldiv;
    logic                  w_div_zero;
    logic [2*DATASIZE-1:0] w_alu_result;

    // Round-robin search starting just after the last granted requester
    always_comb begin : grant_search
        logic [ID_W-1:0] cand;
        w_found = 1'b0;
        w_grant = '0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[cand]) begin
                w_found = 1'b1;
                w_grant = cand;
            end
        end
    end

    // One-hot accept strobe, only while idle and never while reset is held
    always_comb begin
        req_ready = '0;
        if (!rst && (r_state == S_IDLE) && w_found) begin
            req_ready[w_grant] = 1'b1;
        end
    end

    assign w_accept       = !rst && (r_state == S_IDLE) && w_found;
    assign w_grant_muldiv = (req_opcode[w_grant] == MUL) || (req_opcode[w_grant] == DIV);
    assign w_div_zero     = (r_opcode == DIV) && (r_in2 == '0);
    assign out_valid      = (r_state == S_DONE);

    alu_rr_scheduler_alu #(
        .DATASIZE (DATASIZE)
    ) u_alu (
        .i_in1    (r_in1),
        .i_in2    (r_in2),
        .i_opcode (r_opcode),
        .o_result (w_alu_result)
    );

    // Accept / execute / hold-result sequencing with registered operands and result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= ID_W'(NUM_REQ - 1);
            r_id       <= '0;
            r_in1      <= '0;
            r_in2      <= '0;
            r_opcode   <= ADD;
            r_cnt      <= '0;
            out_result <= '0;
            out_id     <= '0;
            out_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_in1    <= req_in1[w_grant];
                        r_in2    <= req_in2[w_grant];
                        r_opcode <= req_opcode[w_grant];
                        r_id     <= w_grant;
                        r_ptr    <= w_grant;
                        r_cnt    <= w_grant_muldiv ? CNT_W'(MULDIV_CYCLES - 1) : '0;
                        r_state  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == '0) begin
                        out_result <= w_div_zero ? '0 : w_alu_result;
                        out_err    <= w_div_zero;
                        out_id     <= r_id;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_RR_SCHEDULER_PERF_EN
    // Saturating counters of completed results and busy (EXEC or DONE) cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ops_done    <= '0;
            busy_cycles <= '0;
        end else begin
            if ((r_state == S_DONE) && out_ready && (ops_done != 16'hFFFF)) begin
                ops_done <= ops_done + 16'd1;
            end
            if (((r_state == S_EXEC) || (r_state == S_DONE)) && (busy_cycles != 16'hFFFF)) begin
                busy_cycles <= busy_cycles + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb/tb_alu_rr_scheduler.sv - self-checking bench for alu_rr_scheduler
module tb_alu_rr_scheduler;
    import definitions::*;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_in1 [4];
    logic [7:0]  req_in2 [4];
    opcodes_t    req_opcode [4];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [1:0]  out_id;
    logic        out_err;
`ifdef ALU_RR_SCHEDULER_PERF_EN
    logic [15:0] ops_done;
    logic [15:0] busy_cycles;
`endif

    alu_rr_scheduler #(
        .DATASIZE      (8),
        .NUM_REQ       (4),
        .MULDIV_CYCLES (4)
    ) dut (
`ifdef ALU_RR_SCHEDULER_PERF_EN
        .ops_done    (ops_done),
        .busy_cycles (busy_cycles),
`endif
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_opcode (req_opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_id     (out_id),
        .out_err    (out_err)
    );

    typedef struct {
        int          req;
        opcodes_t    op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] res;
        logic        err;
        int          lat;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    int m_last = 3;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for out_valid", name);
    endtask

    // Reference result {err, result} from the arithmetic rules
    function automatic logic [16:0] ref_alu(opcodes_t op, int a, int b);
        int   r;
        logic e;
        e = 1'b0;
        case (op)
            ADD: r = a + b;
            SUB: r = (a - b + 65536) % 65536;
            MUL: r = a * b;
            DIV: if (b == 0) begin r = 0; e = 1'b1; end else r = a / b;
            SL:  r = a * 2;
            SR:  r = a / 2;
            AND: r = a & b;
            OR:  r = a | b;
            NOT: r = 255 - a;
            XOR: r = a ^ b;
            default: r = 0;
        endcase
        return {e, 16'(r)};
    endfunction

    function automatic int ref_lat(opcodes_t op);
        return (op == MUL || op == DIV) ? 5 : 2;
    endfunction

    function automatic int rr_pick(int last, logic [3:0] v);
        for (int k = 1; k <= 4; k++) begin
            if (v[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_result", out_result, 0);
        check("rst_out_id", out_id, 0);
        check("rst_out_err", out_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_last = 3;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int c;
        bit seen;
        @(negedge clk);
        req_valid = '0;
        req_valid[v.req] = 1'b1;
        req_in1[v.req] = v.a;
        req_in2[v.req] = v.b;
        req_opcode[v.req] = v.op;
        out_ready = 1'b1;
        #1;
        check($sformatf("v%0d_ready", idx), req_ready, 32'd1 << v.req);
        m_last = v.req;
        @(negedge clk);
        req_valid = '0;
        seen = 0;
        for (c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            timeout_fail($sformatf("v%0d", idx));
        end else begin
            check($sformatf("v%0d_latency", idx), c, v.lat);
            check($sformatf("v%0d_result", idx), out_result, v.res);
            check($sformatf("v%0d_id", idx), out_id, v.req);
            check($sformatf("v%0d_err", idx), out_err, v.err);
            @(negedge clk);
            #1;
            check($sformatf("v%0d_pulse", idx), out_valid, 0);
        end
    endtask

    vec_t        vecs [13];
    int          got [$];
    logic [17:0] sb [$];
    logic [17:0] sbe;
    logic [16:0] ex;
    int          g, g2, c, e, acc_prev, m_wait, idx;
    bit          found, m_pending, drain;
    logic [15:0] m_res;
    logic        m_err;
    int          m_id;

    initial begin
        rst = 1'b1;
        req_valid = '0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_in1[i] = '0;
            req_in2[i] = '0;
            req_opcode[i] = ADD;
        end

        vecs[0]  = '{0, ADD, 8'hF0, 8'h20, 16'h0110, 1'b0, 2};
        vecs[1]  = '{2, MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 5};
        vecs[2]  = '{1, DIV, 8'd7,  8'd0,  16'h0000, 1'b1, 5};
        vecs[3]  = '{1, DIV, 8'd200, 8'd7, 16'd28,   1'b0, 5};
        vecs[4]  = '{3, SUB, 8'h10, 8'h20, 16'hFFF0, 1'b0, 2};
        vecs[5]  = '{0, SL,  8'h81, 8'h55, 16'h0102, 1'b0, 2};
        vecs[6]  = '{1, SR,  8'h81, 8'h55, 16'h0040, 1'b0, 2};
        vecs[7]  = '{2, AND, 8'hCC, 8'hAA, 16'h0088, 1'b0, 2};
        vecs[8]  = '{3, OR,  8'hCC, 8'hAA, 16'h00EE, 1'b0, 2};
        vecs[9]  = '{0, NOT, 8'h0F, 8'h33, 16'h00F0, 1'b0, 2};
        vecs[10] = '{1, XOR, 8'hCC, 8'hAA, 16'h0066, 1'b0, 2};
        vecs[11] = '{2, ADD, 8'hFF, 8'hFF, 16'h01FE, 1'b0, 2};
        vecs[12] = '{3, MUL, 8'h0C, 8'h0D, 16'h009C, 1'b0, 5};

        do_reset();
        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // Round robin with all requesters continuously valid
        do_reset();
        @(negedge clk);
        out_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_opcode[i] = ADD;
            req_in1[i] = 8'(i + 1);
            req_in2[i] = 8'h10;
        end
        got.delete();
        sb.delete();
        for (int cy = 0; cy < 32; cy++) begin
            if (cy > 0) @(negedge clk);
            if (cy == 22) req_valid = '0;
            #1;
            if (out_valid) begin
                if (sb.size() == 0) begin
                    timeout_fail("rr_unexpected_result");
                end else begin
                    sbe = sb.pop_front();
                    check("rr_out_id", out_id, sbe[17:16]);
                    check("rr_out_result", out_result, sbe[15:0]);
                end
            end
            if (req_ready != 0) begin
                idx = -1;
                for (int i = 0; i < 4; i++) if (req_ready[i]) idx = i;
                got.push_back(idx);
                ex = ref_alu(ADD, idx + 1, 16);
                sb.push_back({2'(idx), ex[15:0]});
            end
        end
        check("rr_accept_count_ge6", got.size() >= 6, 1);
        check("rr_scoreboard_empty", sb.size(), 0);
        e = 3;
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            e = rr_pick(e, 4'hF);
            check($sformatf("rr_order%0d", k), got[k], e);
        end
        if (got.size() > 0) m_last = got[got.size() - 1];

        // Result held with out_ready low while all requesters wait
        @(negedge clk);
        out_ready = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            req_opcode[i] = ADD;
            req_in1[i] = 8'(8'h11 * (i + 1));
            req_in2[i] = 8'h01;
        end
        #1;
        g = rr_pick(m_last, 4'hF);
        check("stall_grant", req_ready, 32'd1 << g);
        ex = ref_alu(ADD, req_in1[g], req_in2[g]);
        m_last = g;
        found = 0;
        for (c = 1; c <= 10; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            timeout_fail("stall");
        end else begin
            for (int k = 0; k < 5; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    #1;
                end
                check($sformatf("stall_valid%0d", k), out_valid, 1);
                check($sformatf("stall_result%0d", k), out_result, ex[15:0]);
                check($sformatf("stall_id%0d", k), out_id, g);
                check($sformatf("stall_ready%0d", k), req_ready, 0);
            end
            @(negedge clk);
            out_ready = 1'b1;
            #1;
            check("stall_hs_valid", out_valid, 1);
            @(negedge clk);
            #1;
            g2 = rr_pick(g, 4'hF);
            check("stall_after_valid", out_valid, 0);
            check("stall_next_grant", req_ready, 32'd1 << g2);
            m_last = g2;
        end
        @(negedge clk);
        req_valid = '0;
        repeat (8) @(negedge clk);

        // Reset during EXEC of a requester-3 DIV
        @(negedge clk);
        out_ready = 1'b1;
        req_valid = 4'b1000;
        req_opcode[3] = DIV;
        req_in1[3] = 8'd200;
        req_in2[3] = 8'd3;
        #1;
        check("rstx_grant3", req_ready, 4'b1000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstx_req_ready", req_ready, 0);
        check("rstx_out_valid", out_valid, 0);
        check("rstx_out_result", out_result, 0);
        check("rstx_out_id", out_id, 0);
        check("rstx_out_err", out_err, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check($sformatf("rstx_hold_valid%0d", k), out_valid, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1001;
        req_opcode[0] = ADD;
        req_in1[0] = 8'd1;
        req_in2[0] = 8'd2;
        #1;
        check("rstx_first_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid = '0;
        found = 0;
        for (c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk);
            #1;
            if (out_valid) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            timeout_fail("rstx");
        end else begin
            check("rstx_latency", c, 2);
            check("rstx_id", out_id, 0);
            check("rstx_result", out_result, 16'd3);
            check("rstx_err", out_err, 0);
        end
        repeat (3) @(negedge clk);

        // Randomized traffic against the reference model
        do_reset();
        m_pending = 0;
        m_wait = 0;
        acc_prev = -1;
        m_res = '0;
        m_err = 1'b0;
        m_id = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            drain = (cyc >= 660);
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (req_valid[i] && acc_prev != i) begin
                    if ($urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
                end else if (!drain && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    req_opcode[i] = opcodes_t'(4'($urandom_range(0, 9)));
                    req_in1[i] = 8'($urandom);
                    req_in2[i] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            acc_prev = -1;
            if (m_pending) begin
                check("rnd_out_valid", out_valid, 1);
                check("rnd_out_result", out_result, m_res);
                check("rnd_out_id", out_id, m_id);
                check("rnd_out_err", out_err, m_err);
                check("rnd_ready_busy", req_ready, 0);
                if (out_ready) m_pending = 0;
            end else if (m_wait > 0) begin
                check("rnd_out_valid_exec", out_valid, 0);
                check("rnd_ready_exec", req_ready, 0);
                m_wait--;
                if (m_wait == 0) m_pending = 1;
            end else begin
                g = rr_pick(m_last, req_valid);
                check("rnd_out_valid_idle", out_valid, 0);
                check("rnd_grant", req_ready, (g < 0) ? 32'd0 : (32'd1 << g));
                if (g >= 0) begin
                    ex = ref_alu(req_opcode[g], req_in1[g], req_in2[g]);
                    m_res = ex[15:0];
                    m_err = ex[16];
                    m_id = g;
                    m_wait = ref_lat(req_opcode[g]) - 1;
                    m_last = g;
                    acc_prev = g;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
